// File: rtl/compuertas_param.sv
// compuertas_param: N-input bitwise logic reducer with manual op select and
// an automatic sweep over all six ops, dwelling a programmable number of samples on each.
module compuertas_param #(
    parameter int N  = 3,
    parameter int W  = 1,
    parameter int CW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             act,
    input  logic             modo,
    input  logic [2:0]       sel,
    input  logic [N*W-1:0]   ent,
    input  logic             ent_valid,
    input  logic [CW-1:0]    dwell,
    output logic [W-1:0]     sal,
    output logic             sal_valid,
    output logic [2:0]       sel_act,
    output logic             barrido_fin
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t st;
    logic [2:0] op, cur_op;
    logic [CW-1:0] cnt, dw, cur_dw, cur_cnt, cnt_n;
    logic [W-1:0] r_and, r_or, r_xor, res;
    logic acc, run, last, fin_now;
    always_comb begin
        r_and = '1;
        r_or  = '0;
        r_xor = '0;
        for (int i = 0; i < N; i++) begin
            r_and = r_and & ent[i*W +: W];
            r_or  = r_or  | ent[i*W +: W];
            r_xor = r_xor ^ ent[i*W +: W];
        end
    end
    // IDLE with modo=1 behaves as the first RUN cycle, so a sample on the entry edge already counts under op 001
    assign acc     = act & ent_valid;
    assign run     = act & modo & (st != DONE);
    assign cur_op  = !modo ? sel : (st == DONE) ? 3'd0 : (st == IDLE) ? 3'd1 : op;
    assign cur_dw  = (st == IDLE) ? ((dwell == '0) ? CW'(1) : dwell) : dw;
    assign cur_cnt = (st == IDLE) ? '0 : cnt;
    assign cnt_n   = cur_cnt + 1'b1;
    assign last    = cnt_n == cur_dw;
    assign fin_now = run & acc & last & (cur_op == 3'd6);
    assign res = (cur_op == 3'd1) ? r_and :
                 (cur_op == 3'd2) ? r_or :
                 (cur_op == 3'd3) ? r_xor :
                 (cur_op == 3'd4) ? ~r_and :
                 (cur_op == 3'd5) ? ~r_or :
                 (cur_op == 3'd6) ? ~r_xor : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= IDLE;
            op          <= 3'd1;
            cnt         <= '0;
            dw          <= CW'(1);
            sal         <= '0;
            sal_valid   <= 1'b0;
            sel_act     <= 3'd0;
            barrido_fin <= 1'b0;
        end else begin
            sal_valid   <= acc;
            barrido_fin <= fin_now;
            if (acc) begin
                sal     <= res;
                sel_act <= cur_op;
            end
            if (!(act && modo)) begin
                st  <= IDLE;
                cnt <= '0;
            end else if (st != DONE) begin
                st  <= fin_now ? DONE : RUN;
                op  <= (acc && last) ? cur_op + 3'd1 : cur_op;
                cnt <= acc ? (last ? '0 : cnt_n) : cur_cnt;
                dw  <= cur_dw;
            end
        end
    end
endmodule

// File: tb/tb_compuertas_param.sv
// tb_compuertas_param: randomized self-checking bench for compuertas_param
// against a bit-counting reference model and a sweep-position model.
module tb_compuertas_param;
    logic clk = 0, rst_n = 0, act = 0, modo = 0, ent_valid = 0;
    logic [2:0] sel = 0;
    logic [7:0] dwell = 0;
    logic [2:0] ent1 = 0;
    logic [31:0] ent2 = 0;
    logic [0:0] sal1;
    logic [7:0] sal2;
    logic v1, v2, f1, f2;
    logic [2:0] sa1, sa2;
    int n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    compuertas_param #(.N(3), .W(1), .CW(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .act(act), .modo(modo), .sel(sel), .ent(ent1),
        .ent_valid(ent_valid), .dwell(dwell), .sal(sal1), .sal_valid(v1),
        .sel_act(sa1), .barrido_fin(f1));

    compuertas_param #(.N(4), .W(8), .CW(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .act(act), .modo(modo), .sel(sel), .ent(ent2),
        .ent_valid(ent_valid), .dwell(dwell), .sal(sal2), .sal_valid(v2),
        .sel_act(sa2), .barrido_fin(f2));

    // Per bit: count ones across the vectors and apply the op's rule on that count
    function automatic logic [7:0] model(input logic [2:0] op, input logic [31:0] v, input int nv, input int w);
        logic [7:0] r = '0;
        for (int b = 0; b < w; b++) begin
            int ones = 0;
            bit all, any, odd;
            for (int i = 0; i < nv; i++) ones += int'(v[i*w+b]);
            all = (ones == nv); any = (ones > 0); odd = (ones % 2) == 1;
            r[b] = (op == 1) ? all : (op == 2) ? any : (op == 3) ? odd :
                   (op == 4) ? !all : (op == 5) ? !any : (op == 6) ? !odd : 1'b0;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({sal2, v2, sa2, f2, sal1, v1, sa1, f1} !== '0) begin
            n_fail++; $display("FAIL reset_active: got %h expected 0", {sal2, v2, sa2, f2, sal1, v1, sa1, f1});
        end
        #3 rst_n = 1;
        act = 1; modo = 0; sel = 3'd3; ent_valid = 0;
        tick();
        n_checks++;
        if ({sal2, v2, sa2, f2} !== '0) begin
            n_fail++; $display("FAIL reset_hold: got %h expected 0", {sal2, v2, sa2, f2});
        end
    endtask

    task automatic test_truth_table();
        act = 1; modo = 0; ent_valid = 1;
        for (int s = 0; s < 8; s++) begin
            for (int e = 0; e < 8; e++) begin
                logic [7:0] exp1, exp2;
                sel = 3'(s); ent1 = 3'(e); ent2 = $urandom;
                exp1 = model(3'(s), {29'd0, 3'(e)}, 3, 1);
                exp2 = model(3'(s), ent2, 4, 8);
                tick();
                n_checks++;
                if (sal1 !== exp1[0] || v1 !== 1'b1 || sa1 !== 3'(s)) begin
                    n_fail++; $display("FAIL truth_n3w1 op=%0d ent=%b: got sal=%b v=%b sel=%0d expected sal=%b v=1 sel=%0d", s, e, sal1, v1, sa1, exp1[0], s);
                end
                n_checks++;
                if (sal2 !== exp2 || v2 !== 1'b1 || sa2 !== 3'(s)) begin
                    n_fail++; $display("FAIL truth_n4w8 op=%0d ent=%h: got sal=%h v=%b expected sal=%h", s, ent2, sal2, v2, exp2);
                end
            end
        end
    endtask

    task automatic test_parity_vec();
        act = 1; modo = 0; sel = 3'd3; ent_valid = 1; ent2 = 32'hFF55330F;
        tick();
        n_checks++;
        if (sal2 !== 8'h96 || v2 !== 1'b1) begin
            n_fail++; $display("FAIL xor_vec: got sal=%h v=%b expected sal=96 v=1", sal2, v2);
        end
    endtask

    task automatic test_hold();
        logic [7:0] prev = sal2;
        ent_valid = 0; sel = 3'd1; ent2 = ~ent2;
        repeat (2) begin
            tick();
            n_checks++;
            if (v2 !== 1'b0 || sal2 !== prev || sa2 !== 3'd3) begin
                n_fail++; $display("FAIL hold: got v=%b sal=%h sel=%0d expected v=0 sal=%h sel=3", v2, sal2, sa2, prev);
            end
        end
        act = 0; ent_valid = 1;
        tick();
        n_checks++;
        if (v2 !== 1'b0 || sal2 !== prev) begin
            n_fail++; $display("FAIL act_off: got v=%b sal=%h expected v=0 sal=%h", v2, sal2, prev);
        end
    endtask

    task automatic test_sweep(input logic [7:0] dw, input bit gap, input bit change_dw);
        int eff = (dw == 0) ? 1 : int'(dw);
        act = 1; modo = 1; ent_valid = 0; dwell = dw;
        tick();
        n_checks++;
        if (v2 !== 1'b0 || f2 !== 1'b0) begin
            n_fail++; $display("FAIL sweep_entry: got v=%b fin=%b expected 0 0", v2, f2);
        end
        for (int op = 1; op <= 6; op++) begin
            for (int j = 0; j < eff; j++) begin
                logic [7:0] exp;
                bit fin;
                if (gap) begin
                    ent_valid = 0;
                    tick();
                    n_checks++;
                    if (v2 !== 1'b0 || f2 !== 1'b0) begin
                        n_fail++; $display("FAIL sweep_gap op=%0d: got v=%b fin=%b expected 0 0", op, v2, f2);
                    end
                end
                ent_valid = 1; ent2 = $urandom;
                exp = model(3'(op), ent2, 4, 8);
                fin = (op == 6) && (j == eff - 1);
                tick();
                if (change_dw) dwell = 8'($urandom_range(1, 9));
                n_checks++;
                if (v2 !== 1'b1 || sa2 !== 3'(op) || sal2 !== exp || f2 !== fin) begin
                    n_fail++; $display("FAIL sweep op=%0d n=%0d: got v=%b sel=%0d sal=%h fin=%b expected v=1 sel=%0d sal=%h fin=%b", op, j, v2, sa2, sal2, f2, op, exp, fin);
                end
            end
        end
        repeat (2) begin
            ent_valid = 1; ent2 = $urandom;
            tick();
            n_checks++;
            if (v2 !== 1'b1 || sa2 !== 3'd0 || sal2 !== 8'd0 || f2 !== 1'b0) begin
                n_fail++; $display("FAIL sweep_done: got v=%b sel=%0d sal=%h fin=%b expected 1 0 00 0", v2, sa2, sal2, f2);
            end
        end
        modo = 0; ent_valid = 0;
        tick();
    endtask

    task automatic test_act_drop();
        logic [7:0] prev;
        act = 1; modo = 1; ent_valid = 0; dwell = 8'd1;
        tick();
        for (int op = 1; op <= 2; op++) begin
            ent_valid = 1; ent2 = $urandom;
            tick();
        end
        prev = sal2;
        act = 0; ent_valid = 1;
        repeat (2) begin
            tick();
            n_checks++;
            if (v2 !== 1'b0 || sal2 !== prev || sa2 !== 3'd2) begin
                n_fail++; $display("FAIL act_drop: got v=%b sal=%h sel=%0d expected v=0 sal=%h sel=2", v2, sal2, sa2, prev);
            end
        end
        act = 1; ent_valid = 0; sel = 3'd1;
        tick();
        ent_valid = 1; ent2 = $urandom;
        tick();
        n_checks++;
        if (v2 !== 1'b1 || sa2 !== 3'd1 || sal2 !== model(3'd1, ent2, 4, 8)) begin
            n_fail++; $display("FAIL act_restart: got v=%b sel=%0d expected v=1 sel=1", v2, sa2);
        end
        modo = 0; ent_valid = 0;
        tick();
    endtask

    task automatic test_async_reset();
        act = 1; modo = 1; ent_valid = 0; dwell = 8'd3;
        tick();
        for (int k = 0; k < 4; k++) begin
            ent_valid = 1; ent2 = $urandom | 32'h1;
            tick();
        end
        #2 rst_n = 0;
        #1;
        n_checks++;
        if ({sal2, v2, sa2, f2} !== '0) begin
            n_fail++; $display("FAIL async_reset: got %h expected 0", {sal2, v2, sa2, f2});
        end
        ent_valid = 0;
        @(negedge clk);
        rst_n = 1;
        tick();
        for (int k = 0; k < 4; k++) begin
            logic [2:0] eop = (k < 3) ? 3'd1 : 3'd2;
            ent_valid = 1; ent2 = $urandom;
            tick();
            n_checks++;
            if (v2 !== 1'b1 || sa2 !== eop || sal2 !== model(eop, ent2, 4, 8)) begin
                n_fail++; $display("FAIL reset_restart k=%0d: got v=%b sel=%0d expected v=1 sel=%0d", k, v2, sa2, eop);
            end
        end
        modo = 0; ent_valid = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_parity_vec();
        test_hold();
        test_sweep(8'd2, 1'b0, 1'b1);
        test_sweep(8'd0, 1'b1, 1'b0);
        test_act_drop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
